// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared constants for the MEM pipeline stage.
//   - bus widths between EX/MEM/WB and the ID forwarding bundle
//   - load-op encodings carried on the EX->MEM bus
//   - state encoding of the per-instruction MEM FSM
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_W = 75;
    localparam int MS_TO_WS_BUS_W = 70;
    localparam int RF_COLLECT_W   = 39;

    localparam logic [2:0] LD_W  = 3'b000;
    localparam logic [2:0] LD_B  = 3'b001;
    localparam logic [2:0] LD_H  = 3'b010;
    localparam logic [2:0] LD_BU = 3'b101;
    localparam logic [2:0] LD_HU = 3'b110;

    // IDLE : no memory transaction outstanding (ready_go=1)
    // WAIT : request issued, waiting for data_ok
    // HOLD : response captured, waiting for WB to accept
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } ms_state_e;

endpackage

// File: rtl/mem_stage_load_align.sv
// mem_load_align: combinational load data alignment and extension.
// Ports:
//   rdata  [31:0] in  raw word returned by the data SRAM
//   offset [1:0]  in  byte offset of the access (address bits [1:0])
//   ld_op  [2:0]  in  load kind (ld.w / ld.b / ld.h / ld.bu / ld.hu)
//   result [31:0] out aligned, sign- or zero-extended load value
// Used by mem_stage only when MEM_SUBWORD_LOAD_EN is defined.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  ld_op,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (offset)
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase

        // Halfword accesses are naturally aligned, so only offset[1] matters.
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

        case (ld_op)
            LD_B:    result = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   result = {24'd0, byte_sel};
            LD_H:    result = {{16{half_sel[15]}}, half_sel};
            LD_HU:   result = {16'd0, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with a split-transaction data SRAM interface.
// Holds one instruction; memory ops wait for data_ok, and a response that
// arrives while WB is stalled is buffered so the SRAM need not hold it.
// Ports:
//   clk, reset (sync, active-high)
//   es_to_ms_valid / es_to_ms_bus[74:0]  instruction from EX
//   ms_allowin                           MEM can accept this cycle
//   data_sram_data_ok / data_sram_rdata  SRAM response (one-cycle pulse)
//   ws_allowin                           WB can accept this cycle
//   ms_to_ws_valid / ms_to_ws_bus[69:0]  completed instruction to WB
//   ms_rf_collect[38:0]                  {wait_mem, we, waddr, result} to ID
// Build option: MEM_SUBWORD_LOAD_EN enables byte/halfword load alignment
// (mem_load_align); without it every load returns the raw word.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_W-1:0] es_to_ms_bus,
    output logic                      ms_allowin,
    input  logic                      data_sram_data_ok,
    input  logic [31:0]               data_sram_rdata,
    input  logic                      ws_allowin,
    output logic                      ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_W-1:0] ms_to_ws_bus,
    output logic [RF_COLLECT_W-1:0]   ms_rf_collect
);

    logic                      ms_valid;
    logic [ES_TO_MS_BUS_W-1:0] ms_bus_p1;
    logic [31:0]               ld_buf_p1;
    ms_state_e                 state_q;
    ms_state_e                 state_d;

    logic        accept;
    logic        ms_ready_go;
    logic        ms_wait_mem;
    logic        data_ok_hit;
    logic        buf_we;
    logic        res_from_mem;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
    logic [31:0] pc;
    logic [31:0] load_raw;
    logic [31:0] load_val;
    logic [31:0] final_result;
    logic        unused_mem_req;

    assign res_from_mem   = ms_bus_p1[70];
    assign rf_we          = ms_bus_p1[69];
    assign rf_waddr       = ms_bus_p1[68:64];
    assign ex_result      = ms_bus_p1[63:32];
    assign pc             = ms_bus_p1[31:0];
    // The request kind is already captured by the FSM state on acceptance.
    assign unused_mem_req = ms_bus_p1[74];

    assign accept         = es_to_ms_valid & ms_allowin;
    assign ms_allowin     = ~ms_valid | (ms_ready_go & ws_allowin);
    assign ms_to_ws_valid = ms_valid & ms_ready_go;

    // EX -> MEM boundary: valid, payload and response buffer
    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid  <= 1'b0;
            ms_bus_p1 <= '0;
            ld_buf_p1 <= '0;
        end else begin
            if (ms_allowin) begin
                ms_valid <= es_to_ms_valid;
            end
            if (accept) begin
                ms_bus_p1 <= es_to_ms_bus;
            end
            if (buf_we) begin
                ld_buf_p1 <= data_sram_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // data_ok only counts for a live instruction in WAIT; anything else is stale.
    always_comb begin
        ms_ready_go = 1'b1;
        ms_wait_mem = 1'b0;
        data_ok_hit = 1'b0;
        if (state_q == WAIT) begin
            data_ok_hit = ms_valid & data_sram_data_ok;
            ms_ready_go = data_ok_hit;
            ms_wait_mem = ms_valid & ~data_sram_data_ok & res_from_mem;
        end
    end

    // Whenever the slot turns over, the next state is set by what enters it;
    // otherwise the only transition is WAIT -> HOLD on a response WB can't take.
    always_comb begin
        state_d = state_q;
        buf_we  = 1'b0;
        if (ms_allowin) begin
            state_d = (accept && es_to_ms_bus[74]) ? WAIT : IDLE;
        end else if (data_ok_hit) begin
            state_d = HOLD;
            buf_we  = 1'b1;
        end
    end

    // MEM -> WB boundary: result selection
    assign load_raw = (state_q == HOLD) ? ld_buf_p1 : data_sram_rdata;

`ifdef MEM_SUBWORD_LOAD_EN
    logic [2:0] ld_op;
    assign ld_op = ms_bus_p1[73:71];

    mem_load_align u_load_align (
        .rdata  (load_raw),
        .offset (ex_result[1:0]),
        .ld_op  (ld_op),
        .result (load_val)
    );
`else
    logic [2:0] unused_ld_op;
    assign unused_ld_op = ms_bus_p1[73:71];
    assign load_val     = load_raw;
`endif

    assign final_result  = res_from_mem ? load_val : ex_result;
    assign ms_to_ws_bus  = {rf_we, rf_waddr, final_result, pc};
    assign ms_rf_collect = {ms_wait_mem, rf_we & ms_valid, rf_waddr, final_result};

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized scoreboard bench for mem_stage.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        es_to_ms_valid;
    logic [74:0] es_to_ms_bus;
    logic        ms_allowin;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        ws_allowin;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic [38:0] ms_rf_collect;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_allowin        (ms_allowin),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ms_rf_collect     (ms_rf_collect)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [69:0] sb[$];

    typedef struct {
        int          lat;
        logic [31:0] rd;
    } mem_rsp_t;
    mem_rsp_t mq[$];

    logic        resp_ok, force_ok;
    logic [31:0] resp_rd, force_rd;
    assign data_sram_data_ok = resp_ok | force_ok;
    assign data_sram_rdata   = force_ok ? force_rd : resp_rd;

    logic ws_mode, ws_force, ws_rand;
    assign ws_allowin = ws_mode ? ws_force : ws_rand;

    task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference load result from the ISA rules.
    function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [1:0] off,
                                               input logic [2:0] op);
`ifdef MEM_SUBWORD_LOAD_EN
        int unsigned b, h;
        b = (rd >> (8 * off)) & 32'hff;
        h = (rd >> (16 * (off / 2))) & 32'hffff;
        case (op)
            3'b001:  return (b >= 128) ? b + 32'hffffff00 : b;
            3'b101:  return b;
            3'b010:  return (h >= 32768) ? h + 32'hffff0000 : h;
            3'b110:  return h;
            default: return rd;
        endcase
`else
        logic [4:0] unused_args;
        unused_args = {off, op};
        return rd;
`endif
    endfunction

    // SRAM responder: data_ok pulses lat cycles after acceptance.
    initial begin
        int          cnt;
        logic [31:0] r;
        bit          active;
        mem_rsp_t    m;
        resp_ok = 1'b0;
        resp_rd = '0;
        cnt = 0;
        r = '0;
        active = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            resp_ok = 1'b0;
            resp_rd = $urandom;
            if (!active && mq.size() > 0) begin
                m = mq.pop_front();
                cnt = m.lat;
                r = m.rd;
                active = 1'b1;
            end
            if (active) begin
                if (cnt == 0) begin
                    resp_ok = 1'b1;
                    resp_rd = r;
                    active = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    initial begin
        ws_rand = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ws_rand = ($urandom_range(0, 9) < 7);
        end
    end

    // Monitor: every WB transfer must match the oldest expected entry.
    always @(negedge clk) begin
        logic [69:0] exp;
        if (!reset && ms_to_ws_valid && ws_allowin) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_retire: got bus %h, expected no transfer", ms_to_ws_bus);
            end else begin
                exp = sb.pop_front();
                check("retire_bus", ms_to_ws_bus, exp);
            end
        end
    end

    // Present one instruction and hold it until accepted; returns 1ns after the accepting edge.
    task automatic issue(input bit mem_req, input logic [2:0] op, input bit rfm, input bit we,
                         input logic [4:0] wa, input logic [31:0] ex, input logic [31:0] pc,
                         input int lat, input logic [31:0] rd, input bit respond);
        bit          acc;
        logic [31:0] fin;
        mem_rsp_t    m;
        fin = rfm ? model_load(rd, ex[1:0], op) : ex;
        es_to_ms_bus = {mem_req, op, rfm, we, wa, ex, pc};
        es_to_ms_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 300 && !acc; i++) begin
            @(negedge clk);
            if (ms_allowin) begin
                acc = 1'b1;
                sb.push_back({we, wa, fin, pc});
                if (mem_req && respond) begin
                    m.lat = lat;
                    m.rd = rd;
                    mq.push_back(m);
                end
            end
            @(posedge clk);
            #1;
        end
        es_to_ms_valid = 1'b0;
        es_to_ms_bus = {11'($urandom), $urandom, $urandom};
        if (!acc) begin
            n_chk++;
            $display("FAIL accept_timeout: ms_allowin stayed 0, expected acceptance");
        end
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (sb.size() > 0 && i < 500) begin
            @(posedge clk);
            #1;
            i++;
        end
        if (sb.size() > 0) begin
            n_chk++;
            $display("FAIL drain_timeout: %0d entries outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int          cnt;
        bit          done;
        int          kind;
        logic [2:0]  op;
        logic [2:0]  ops [5];
        ops = '{LD_W, LD_B, LD_H, LD_BU, LD_HU};

        reset = 1'b1;
        es_to_ms_valid = 1'b0;
        es_to_ms_bus = '0;
        force_ok = 1'b0;
        force_rd = '0;
        ws_mode = 1'b1;
        ws_force = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_allowin", 70'(ms_allowin), 70'(1));
        check("reset_to_ws_valid", 70'(ms_to_ws_valid), 70'(0));
        check("reset_rf_collect", 70'(ms_rf_collect), 70'(0));
        @(posedge clk);
        #1;

        // ALU op retires in its first MEM cycle
        issue(1'b0, LD_W, 1'b0, 1'b1, 5'd3, 32'h1234, 32'h1c000000, 0, 32'h0, 1'b1);
        @(negedge clk);
        check("alu_same_cycle", 70'(ms_to_ws_valid), 70'(1));
        check("alu_result", 70'(ms_to_ws_bus[63:32]), 70'(32'h1234));
        @(posedge clk);
        #1;

        // ld.w with data_ok three cycles after acceptance
        issue(1'b1, LD_W, 1'b1, 1'b1, 5'd4, 32'h100, 32'h1c000004, 3, 32'hDEADBEEF, 1'b1);
        cnt = 0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (ms_rf_collect[38]) cnt++;
            if (ms_to_ws_valid) begin
                done = 1'b1;
                check("ldw_retire_on_data_ok", 70'(data_sram_data_ok), 70'(1));
            end
            if (!done) begin
                @(posedge clk);
                #1;
            end
        end
        check("ldw_retired", 70'(done), 70'(1));
        check("ldw_wait_mem_cycles", 70'(cnt), 70'(3));
        @(posedge clk);
        #1;

        // sub-word loads
        issue(1'b1, LD_B,  1'b1, 1'b1, 5'd5, 32'h203, 32'h1c000008, 1, 32'h80FF0011, 1'b1);
        issue(1'b1, LD_BU, 1'b1, 1'b1, 5'd6, 32'h203, 32'h1c00000c, 1, 32'h80FF0011, 1'b1);
        issue(1'b1, LD_HU, 1'b1, 1'b1, 5'd7, 32'h202, 32'h1c000010, 1, 32'h80FF0011, 1'b1);
        drain();

        // response while WB stalled: buffered in HOLD
        ws_force = 1'b0;
        issue(1'b1, LD_H, 1'b1, 1'b1, 5'd8, 32'h302, 32'h1c000014, 0, 32'h80017FFE, 1'b1);
        @(negedge clk);
        check("hold_c0_allowin", 70'(ms_allowin), 70'(0));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("hold_c1_allowin", 70'(ms_allowin), 70'(0));
        check("hold_c1_valid", 70'(ms_to_ws_valid), 70'(1));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("hold_c2_allowin", 70'(ms_allowin), 70'(0));
        @(posedge clk);
        #1;
        ws_force = 1'b1;
        drain();

        // reset while waiting; a late data_ok must be ignored
        issue(1'b1, LD_W, 1'b1, 1'b1, 5'd9, 32'h40, 32'h1c000018, 0, 32'h0, 1'b0);
        void'(sb.pop_back());
        reset = 1'b1;
        @(negedge clk);
        check("rst_wait_mem_before", 70'(ms_rf_collect[38]), 70'(1));
        @(posedge clk);
        #1;
        reset = 1'b0;
        force_ok = 1'b1;
        force_rd = 32'hBAD0BAD0;
        @(negedge clk);
        check("rst_allowin", 70'(ms_allowin), 70'(1));
        check("rst_to_ws_valid", 70'(ms_to_ws_valid), 70'(0));
        check("rst_rf_collect", 70'(ms_rf_collect), 70'(0));
        @(posedge clk);
        #1;
        force_ok = 1'b0;
        @(negedge clk);
        check("rst_after_ok_allowin", 70'(ms_allowin), 70'(1));
        check("rst_after_ok_valid", 70'(ms_to_ws_valid), 70'(0));
        @(posedge clk);
        #1;
        issue(1'b0, LD_W, 1'b0, 1'b1, 5'd10, 32'h5555AAAA, 32'h1c00001c, 0, 32'h0, 1'b1);
        @(negedge clk);
        check("rst_then_alu_same_cycle", 70'(ms_to_ws_valid), 70'(1));
        @(posedge clk);
        #1;
        drain();

        // randomized traffic with random WB back-pressure
        ws_mode = 1'b0;
        for (int n = 0; n < 150; n++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            kind = $urandom_range(0, 2);
            op = ops[$urandom_range(0, 4)];
            case (kind)
                0: issue(1'b0, 3'($urandom), 1'b0, 1'($urandom), 5'($urandom), $urandom, $urandom,
                         0, 32'h0, 1'b1);
                1: issue(1'b1, 3'($urandom), 1'b0, 1'b0, 5'($urandom), $urandom, $urandom,
                         $urandom_range(0, 4), $urandom, 1'b1);
                default: issue(1'b1, op, 1'b1, 1'b1, 5'($urandom), $urandom, $urandom,
                               $urandom_range(0, 4), $urandom, 1'b1);
            endcase
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed constants from the shared package.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 es_to_ms_valid  in  1  EX stage holds a valid instruction for MEM.
REQ-005 es_to_ms_bus  in  75  {mem_req[74], ld_op[73:71], res_from_mem[70], rf_we[69], rf_waddr[68:64], ex_result[63:32], pc[31:0]}.
REQ-006 ms_allowin  out  1  MEM can accept a new instruction this cycle.
REQ-007 data_sram_data_ok  in  1  one-cycle pulse; read/write response for the oldest accepted request.
REQ-008 data_sram_rdata  in  32  read data; valid only when data_sram_data_ok=1.
REQ-009 ws_allowin  in  1  WB can accept this cycle.
REQ-010 ms_to_ws_valid  out  1  MEM presents a completed instruction to WB.
REQ-011 ms_to_ws_bus  out  70  {rf_we, rf_waddr[4:0], final_result[31:0], pc[31:0]}.
REQ-012 ms_rf_collect  out  39  {ms_wait_mem, rf_we&ms_valid, rf_waddr, final_result}, used by ID for forwarding/stall.

Function
REQ-013 ms_valid SHALL load es_to_ms_valid when ms_allowin=1; the payload register SHALL load es_to_ms_bus only when es_to_ms_valid & ms_allowin.
REQ-014 ms_allowin SHALL equal ~ms_valid | (ms_ready_go & ws_allowin); ms_to_ws_valid SHALL equal ms_valid & ms_ready_go.
REQ-015 A per-instruction FSM SHALL have states IDLE, WAIT, HOLD.
REQ-016 On acceptance: mem_req=1 -> WAIT; otherwise -> IDLE (ready_go=1 immediately, zero added latency).
REQ-017 WAIT + data_ok + ws_allowin: instruction SHALL retire the same cycle with rdata used combinationally; next state follows the incoming instruction (or IDLE).
REQ-018 WAIT + data_ok + ~ws_allowin: rdata SHALL be captured into a 32-bit buffer, state -> HOLD; HOLD SHALL present buffered data until ws_allowin.
REQ-019 ms_ready_go SHALL be 1 in IDLE, in HOLD, and in WAIT only during the data_ok cycle.
REQ-020 ms_wait_mem SHALL be 1 in WAIT with data_ok=0 and res_from_mem=1 (ID must stall, not forward).
REQ-021 data_ok while ~ms_valid or state≠WAIT SHALL be ignored (no state change, no buffer write).
REQ-022 final_result SHALL be the aligned load value when res_from_mem=1, else ex_result; stores (mem_req=1, res_from_mem=0) SHALL still wait for data_ok.
REQ-023 ld_op encoding: 000 ld.w, 001 ld.b, 010 ld.h, 101 ld.bu, 110 ld.hu; byte offset = ex_result[1:0]; halfword uses ex_result[1].
REQ-024 ld.b/ld.h SHALL sign-extend, ld.bu/ld.hu SHALL zero-extend the selected byte/halfword to 32 bits.

Reset
REQ-025 On reset: ms_valid=0, FSM=IDLE, payload and buffer=0; hence ms_allowin=1, ms_to_ws_valid=0, ms_rf_collect=0 the following cycle.
REQ-026 Reset during WAIT SHALL abandon the instruction; a data_ok arriving after reset SHALL be ignored per REQ-021.

Configuration
REQ-027 Macro MEM_SUBWORD_LOAD_EN: defined -> REQ-023/024 alignment and extension active; undefined -> ld_op ignored, loads return rdata unchanged (ld.w only), alignment logic absent.

Structure
REQ-028 Shared package SHALL hold ld_op encodings, ES_TO_MS_BUS_W=75, MS_TO_WS_BUS_W=70, RF_COLLECT_W=39 and FSM state encoding.
REQ-029 Alignment/extension SHALL be a combinational sub-module mem_load_align (rdata, offset, ld_op -> result), instantiated only under MEM_SUBWORD_LOAD_EN.

Verification
REQ-030 ALU op, ex_result=0x1234, ws_allowin=1 -> ms_to_ws_valid same cycle as ms_valid, final_result=0x1234.
REQ-031 ld.w, data_ok 3 cycles after acceptance, rdata=0xDEADBEEF -> ms_wait_mem=1 for 3 cycles, retire in the data_ok cycle with 0xDEADBEEF.
REQ-032 ld.b offset 3 rdata=0x80FF0011 -> 0xFFFFFF80; ld.bu -> 0x00000080; ld.hu offset 2 -> 0x000080FF.
REQ-033 data_ok with ws_allowin=0 for 2 cycles -> HOLD, ms_allowin=0, buffered value delivered unchanged when ws_allowin rises.
REQ-034 reset asserted in WAIT, data_ok pulse next cycle -> ms_valid stays 0, no WB transfer, FSM=IDLE.
